// File: rtl/uart_loader_pkg.sv
// Shared widths, FSM encodings and address helper for the UART program loader.
package uart_loader_pkg;

  localparam int UART_DATA_WID = 32;
  localparam int ADDR_WID      = 32;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_RECV, L_HOLD, L_DONE} ld_state_t;

  function automatic logic [ADDR_WID-1:0] word_addr(input logic [ADDR_WID-1:0] idx,
                                                    input int step);
    return idx * ADDR_WID'(step);
  endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Memory-port-B write bus driven by the loader while the core is held in reset.
interface uart_loader_if;
  import uart_loader_pkg::*;

  logic [UART_DATA_WID-1:0] uart_data;
  logic [ADDR_WID-1:0]      uart_addr;
  logic                     uart_done;

  modport master (output uart_data, uart_addr, uart_done);
  modport slave  (input  uart_data, uart_addr, uart_done);
endinterface

// File: rtl/uart_loader_rx.sv
// UART byte receiver: 2-flop synchronizer, start-bit glitch rejection, 8N1 framing.
module uart_loader_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state;
  logic          rx_meta, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign busy = (state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta         <= 1'b1;
      rx_s            <= 1'b1;
      rx_d            <= 1'b1;
      state           <= RX_IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      byte_valid      <= 1'b0;
      byte_data       <= '0;
      frame_err_pulse <= 1'b0;
    end else begin
      rx_meta         <= rx;
      rx_s            <= rx_meta;
      rx_d            <= rx_s;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_d && !rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else frame_err_pulse <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: packs UART bytes little-endian into words and streams them to memory.
// Optional idle-timeout finish is enabled with `define UART_LOADER_TIMEOUT_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter int WORD_COUNT  = 16384,
  parameter int ADDR_STEP   = 4,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         skip,
  uart_loader_if.master mem,
  output logic         frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int WIW          = $clog2(WORD_COUNT) + 1;

  logic                     byte_valid, frame_err_pulse, rx_busy;
  logic [7:0]               byte_data;
  ld_state_t                state;
  logic [1:0]               byte_idx;
  logic [WIW-1:0]           word_idx;
  logic [UART_DATA_WID-1:0] word_buf, asm_word, commit_word;
  logic [UART_DATA_WID-1:0] data_q;
  logic [ADDR_WID-1:0]      addr_q;
  logic                     done_q, hold_cnt;
  logic                     tmo, tmo_fire, bv_commit, pad_commit, commit, last;

  uart_loader_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .frame_err_pulse (frame_err_pulse),
    .busy            (rx_busy)
  );

  assign mem.uart_data = data_q;
  assign mem.uart_addr = addr_q;
  assign mem.uart_done = done_q;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;

  // Idle means no frame in flight; the count saturates at the threshold.
  always_ff @(posedge clk) begin
    if (rst || byte_valid || rx_busy || state != L_RECV) idle_cnt <= '0;
    else if (idle_cnt != TW'(TIMEOUT_CYC))               idle_cnt <= idle_cnt + 1'b1;
  end

  assign tmo = (idle_cnt == TW'(TIMEOUT_CYC)) && (word_idx != '0 || byte_idx != 2'd0);
`else
  localparam int unused_tmo_cyc = TIMEOUT_CYC;
  logic unused_busy;
  assign unused_busy = rx_busy;
  assign tmo         = 1'b0;
`endif

  always_comb begin
    asm_word = word_buf;
    asm_word[8*byte_idx +: 8] = byte_data;
  end

  // word_buf is cleared on every commit, so a timed-out partial word is already zero-padded.
  assign bv_commit   = byte_valid && (byte_idx == 2'd3);
  assign tmo_fire    = (state == L_RECV) && tmo && !byte_valid;
  assign pad_commit  = tmo_fire && (byte_idx != 2'd0);
  assign commit      = (state == L_RECV) && (bv_commit || pad_commit);
  assign commit_word = bv_commit ? asm_word : word_buf;
  assign last        = (word_idx == WIW'(WORD_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= L_RECV;
      byte_idx  <= '0;
      word_idx  <= '0;
      word_buf  <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      hold_cnt  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (frame_err_pulse && state != L_DONE) frame_err <= 1'b1;
      case (state)
        L_RECV: begin
          if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            word_buf <= bv_commit ? '0 : asm_word;
          end
          if (commit) begin
            data_q   <= commit_word;
            addr_q   <= word_addr(ADDR_WID'(word_idx), ADDR_STEP);
            word_idx <= word_idx + 1'b1;
          end
          if (pad_commit) begin
            byte_idx <= '0;
            word_buf <= '0;
          end
          if (skip) begin
            state  <= L_DONE;
            done_q <= 1'b1;
          end else if ((commit && last) || tmo_fire) begin
            state    <= L_HOLD;
            hold_cnt <= 1'b0;
          end
        end
        L_HOLD: begin
          if (hold_cnt) state <= L_DONE;
          else          hold_cnt <= 1'b1;
        end
        L_DONE:  done_q <= 1'b1;
        default: state  <= L_RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: table of serial bytes with expected bus state, plus corner sequences.
module tb_uart_loader;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst, skip, rx_a, rx_b, ferr_a, ferr_b;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, commit_cyc = 0, done_cyc = 0;
  logic [31:0] prev_data;
  logic        prev_done;

  always #5 clk = ~clk;

  uart_loader_if mem_a ();
  uart_loader_if mem_b ();

  uart_loader #(.CLK_FREQ(1_600_000), .BAUD(100_000), .WORD_COUNT(2),
                .ADDR_STEP(4), .TIMEOUT_CYC(2_000_000)) u_dut (
    .clk(clk), .rst(rst), .rx(rx_a), .skip(skip), .mem(mem_a), .frame_err(ferr_a));

  uart_loader #(.CLK_FREQ(1_600_000), .BAUD(100_000), .WORD_COUNT(8),
                .ADDR_STEP(4), .TIMEOUT_CYC(100)) u_dut_t (
    .clk(clk), .rst(rst), .rx(rx_b), .skip(1'b0), .mem(mem_b), .frame_err(ferr_b));

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of each word commit and of the rising edge of uart_done.
  always @(negedge clk) begin
    if (rst) begin
      commit_cyc = 0;
      done_cyc   = 0;
    end else begin
      if (mem_a.uart_data != prev_data) commit_cyc = cyc;
      if (mem_a.uart_done && !prev_done) done_cyc = cyc;
    end
    prev_data = mem_a.uart_data;
    prev_done = mem_a.uart_done;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_line(input logic sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_byte(input logic sel, input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_line(sel, frame[i]);
      repeat (CPB) @(negedge clk);
    end
    set_line(sel, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        do_rst;
    logic [7:0]  b;
    logic        stop;
    logic [31:0] data;
    logic [31:0] addr;
    logic        done;
    logic        ferr;
    logic        chk_lat;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b0, 8'h78, 1'b1, 32'h0,        32'h0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h56, 1'b1, 32'h0,        32'h0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h34, 1'b1, 32'h0,        32'h0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h12, 1'b1, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'hEF, 1'b1, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'hBE, 1'b1, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'hAD, 1'b1, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'hDE, 1'b1, 32'hDEADBEEF, 32'h4, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h55, 1'b1, 32'hDEADBEEF, 32'h4, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'hA5, 1'b0, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h01, 1'b1, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h02, 1'b1, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h03, 1'b1, 32'h0,        32'h0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 8'h04, 1'b1, 32'h04030201, 32'h0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 8'h99, 1'b1, 32'h0,        32'h0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h88, 1'b1, 32'h0,        32'h0, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 8'h11, 1'b1, 32'h0,        32'h0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; skip = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", mem_a.uart_data, 32'h0);
    check("rst_addr", mem_a.uart_addr, 32'h0);
    check("rst_done", {31'b0, mem_a.uart_done}, 32'h0);
    check("rst_ferr", {31'b0, ferr_a}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].do_rst) do_reset();
      send_byte(1'b0, tbl[i].b, tbl[i].stop);
      check($sformatf("v%0d_data", i), mem_a.uart_data, tbl[i].data);
      check($sformatf("v%0d_addr", i), mem_a.uart_addr, tbl[i].addr);
      check($sformatf("v%0d_done", i), {31'b0, mem_a.uart_done}, {31'b0, tbl[i].done});
      check($sformatf("v%0d_ferr", i), {31'b0, ferr_a}, {31'b0, tbl[i].ferr});
      if (tbl[i].chk_lat) check("done_latency", done_cyc - commit_cyc, 32'd3);
    end

    // Remaining bytes of the post-reset word from the last table row.
    send_byte(1'b0, 8'h22, 1'b1);
    send_byte(1'b0, 8'h33, 1'b1);
    send_byte(1'b0, 8'h44, 1'b1);
    check("rst_reload_data", mem_a.uart_data, 32'h44332211);
    check("rst_reload_addr", mem_a.uart_addr, 32'h0);

    // Short low glitch between bytes must not shift the byte index.
    do_reset();
    send_byte(1'b0, 8'h11, 1'b1);
    send_byte(1'b0, 8'h22, 1'b1);
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_ferr", {31'b0, ferr_a}, 32'h0);
    check("glitch_data", mem_a.uart_data, 32'h0);
    send_byte(1'b0, 8'h33, 1'b1);
    send_byte(1'b0, 8'h44, 1'b1);
    check("glitch_word", mem_a.uart_data, 32'h44332211);

    // skip with a partial word pending.
    do_reset();
    send_byte(1'b0, 8'hAB, 1'b1);
    send_byte(1'b0, 8'hCD, 1'b1);
    check("skip_pre_done", {31'b0, mem_a.uart_done}, 32'h0);
    skip = 1'b1;
    @(negedge clk);
    skip = 1'b0;
    check("skip_done", {31'b0, mem_a.uart_done}, 32'h1);
    check("skip_data", mem_a.uart_data, 32'h0);
    send_byte(1'b0, 8'hEF, 1'b1);
    send_byte(1'b0, 8'h01, 1'b1);
    check("skip_frozen", mem_a.uart_data, 32'h0);
    check("skip_addr", mem_a.uart_addr, 32'h0);

`ifdef UART_LOADER_TIMEOUT_EN
    do_reset();
    send_byte(1'b1, 8'h01, 1'b1);
    send_byte(1'b1, 8'h02, 1'b1);
    send_byte(1'b1, 8'h03, 1'b1);
    send_byte(1'b1, 8'h04, 1'b1);
    check("tmo_w0_data", mem_b.uart_data, 32'h04030201);
    send_byte(1'b1, 8'hAA, 1'b1);
    send_byte(1'b1, 8'hBB, 1'b1);
    check("tmo_pre_done", {31'b0, mem_b.uart_done}, 32'h0);
    check("tmo_pre_data", mem_b.uart_data, 32'h04030201);
    begin
      int waited;
      waited = 0;
      while (!mem_b.uart_done && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      check("tmo_done", {31'b0, mem_b.uart_done}, 32'h1);
    end
    check("tmo_w1_data", mem_b.uart_data, 32'h0000BBAA);
    check("tmo_w1_addr", mem_b.uart_addr, 32'h4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Boot-time program loader sitting directly upstream of the CPU core.
- Receives a serial byte stream on the UART RX pin and assembles bytes little-endian into 32-bit words.
- Presents each word with its byte address on uart_data / uart_addr, which the core muxes onto memory port B while uart_done is low.
- Raises uart_done when loading finishes; this releases the core from reset (core rst = ~rst_n | ~uart_done).

Parameters:
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD, 115_200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer divide, must be >= 4).
- WORD_COUNT, 16384, number of 32-bit words to load before done.
- ADDR_STEP, 4, uart_addr increment per word (byte addressing).
- TIMEOUT_CYC, 2_000_000, idle cycles ending a load (only with the optional feature).

Ports:
- clk  in  1  single clock, same domain as memclk.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART RX line, idle high.
- skip  in  1  level; forces an immediate finish (run the program already in memory).
- uart_data  out  32  word to write to memory.
- uart_addr  out  32  byte address of uart_data.
- uart_done  out  1  load finished; sticky until rst.
- frame_err  out  1  sticky; set when any stop bit sampled 0.

Behaviour:
- Reset values: uart_data=0, uart_addr=0, uart_done=0, frame_err=0, word index=0, byte index=0, FSM=IDLE.
- RX front end:
  - rx passes through a 2-flop synchronizer; the sampled line starts as 1 on reset.
  - RX FSM states RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START on a sampled falling edge.
  - RX_START: wait CLKS_PER_BIT/2 cycles; if the line is still 0 go to RX_DATA, else return to RX_IDLE (glitch rejected).
  - RX_DATA: sample 8 bits LSB first, each CLKS_PER_BIT apart, at bit centre.
  - RX_STOP: after CLKS_PER_BIT, sample the stop bit. If 1, pulse byte_valid for 1 cycle with the byte. If 0, set frame_err and drop the byte.
  - Return to RX_IDLE in both cases.
- Loader FSM states L_RECV, L_HOLD, L_DONE.
  - L_RECV: each byte_valid shifts the byte into word[8*byte_idx +: 8]; byte_idx wraps 3 -> 0.
  - On the 4th byte, in the next cycle: uart_data <= assembled word and uart_addr <= word_idx*ADDR_STEP, updated in the same cycle; then word_idx++.
  - uart_data and uart_addr hold stable between commits.
  - When the committed word is word WORD_COUNT-1: go to L_HOLD. L_HOLD lasts 2 cycles so the memory captures the final word, then go to L_DONE.
  - L_DONE: uart_done=1. All rx activity is ignored; outputs are frozen until rst.
- skip=1 in L_RECV: go to L_DONE next cycle. Any partial word is discarded; no commit happens.
  - skip and a commit in the same cycle: the commit happens, then L_DONE.
- A framing error does not reset byte_idx; the dropped byte is simply absent.
- rst mid-load: everything returns to reset values; the next byte is treated as byte 0 of word 0.
- word_idx is sized clog2(WORD_COUNT)+1 bits and never wraps, because L_DONE is terminal.

Optional Feature:
- Macro UART_LOADER_TIMEOUT_EN.
- Defined: a counter clears on every byte_valid and increments while in L_RECV. When it reaches TIMEOUT_CYC, word_idx >= 1 and byte_idx == 0, go to L_HOLD and then L_DONE. Programs shorter than WORD_COUNT therefore finish without padding.
  - If a partial word is pending at timeout, it is zero-padded in its upper bytes and committed first.
- Not defined: no counter exists; done occurs only via WORD_COUNT words or skip.

Decomposition:
- Shared package (Const.svh): UART_DATA_WID=32, ADDR_WID=32, and the RX and loader state enums.
- Sub-module uart_rx: synchronizer, RX FSM, outputs byte_valid/byte_data/frame_err_pulse.
- uart_loader holds only the assembly logic, the loader FSM and the timeout logic.

Test Plan:
Common bench setup: CLKS_PER_BIT=16, WORD_COUNT=2.
1. Send 0x78,0x56,0x34,0x12 -> one cycle after the 4th byte_valid, uart_data=0x12345678 and uart_addr=0; uart_done stays 0.
2. Then send 0xEF,0xBE,0xAD,0xDE -> uart_data=0xDEADBEEF, uart_addr=4; uart_done=1 exactly 3 cycles after that commit. Further bytes leave the outputs unchanged.
3. Send byte 0xA5 with stop bit 0 -> frame_err=1, no byte accepted. Then 0x01,0x02,0x03,0x04 -> uart_data=0x04030201.
4. Apply a 3-cycle low glitch on rx -> no byte_valid and byte_idx unchanged. Separately, assert skip after 2 bytes -> uart_done=1 next cycle, uart_data=0.
5. Assert rst after 2 bytes, then send 4 fresh bytes 0x11,0x22,0x33,0x44 -> uart_data=0x44332211 at uart_addr=0.
6. With UART_LOADER_TIMEOUT_EN, TIMEOUT_CYC=100, WORD_COUNT=8: send 6 bytes then idle -> commits 0x.. (word 0), then word 1 = 0x0000_BBAA (upper bytes zero-padded) at addr 4; uart_done=1 after the hold.
